// File: rtl/hilo_muldiv_sched_pkg.sv
// Shared definitions for the HI/LO multiply/divide scheduler: op codes, FSM encoding, default width.
package hilo_muldiv_sched_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_WAIT = 2'd2,
    ST_WB       = 2'd3
  } state_t;

  function automatic logic is_signed_op(input logic [2:0] oc);
    return (oc == OP_MULT) || (oc == OP_DIV);
  endfunction

endpackage

// File: rtl/hilo_muldiv_cnt.sv
// Cycle counter with load, shared by the multiplier latency countdown and the divider watchdog.
module hilo_muldiv_cnt #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec)  cnt <= cnt - W'(1);
    else if (inc)  cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/hilo_muldiv_sched.sv
// HI/LO owner and scheduler for MULT/MULTU/DIV/DIVU/MTHI/MTLO onto external multiplier and divider.
// Optional build macro HILO_FWD_EN: forward the pending result onto hi/lo during WB.
//
// state       | meaning
// ST_IDLE     | accepting ops; MTHI/MTLO write directly
// ST_MUL_WAIT | counting down the fixed multiplier latency
// ST_DIV_WAIT | waiting for div_done, watchdog counting up
// ST_WB       | writing result regs into HI/LO
module hilo_muldiv_sched
  import hilo_muldiv_sched_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MUL_LAT     = 2,
  parameter int DIV_MAX_CYC = 40
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                op_valid,
  input  logic [2:0]          op_code,
  input  logic [DATA_W-1:0]   op_a,
  input  logic [DATA_W-1:0]   op_b,
  output logic                op_ready,
  input  logic                flush,
  output logic                mul_start,
  output logic                mul_signed,
  input  logic [2*DATA_W-1:0] mul_result,
  output logic                div_start,
  output logic                div_signed,
  output logic                div_cancel,
  input  logic                div_done,
  input  logic [DATA_W-1:0]   div_quot,
  input  logic [DATA_W-1:0]   div_rem,
  output logic [DATA_W-1:0]   hi,
  output logic [DATA_W-1:0]   lo,
  output logic                hilo_busy,
  output logic                div_err
);

  localparam int CNT_TOP = (MUL_LAT > DIV_MAX_CYC) ? MUL_LAT : DIV_MAX_CYC;
  localparam int CW      = $clog2(CNT_TOP + 1);

  state_t              state, state_nx;
  logic [DATA_W-1:0]   hi_q, lo_q, res_hi, res_lo;
  logic [DATA_W-1:0]   hi_d, lo_d, res_hi_d, res_lo_d;
  logic                hi_we, lo_we, res_we;
  logic                sign_q, sign_we, err_set;
  logic                cnt_load, cnt_dec, cnt_inc;
  logic [CW-1:0]       cnt_val, cnt;

  hilo_muldiv_cnt #(.W(CW)) u_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .inc      (cnt_inc),
    .cnt      (cnt)
  );

  assign op_ready = (state == ST_IDLE) && !flush;

  // Signedness is live with the start pulse, then held for the rest of the op.
  assign mul_signed = (state == ST_IDLE) ? (op_code == OP_MULT) : sign_q;
  assign div_signed = (state == ST_IDLE) ? (op_code == OP_DIV)  : sign_q;

  always_comb begin
    state_nx   = state;
    mul_start  = 1'b0;
    div_start  = 1'b0;
    div_cancel = 1'b0;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    cnt_dec    = 1'b0;
    cnt_inc    = 1'b0;
    res_we     = 1'b0;
    res_hi_d   = res_hi;
    res_lo_d   = res_lo;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    sign_we    = 1'b0;
    err_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (op_valid && !flush) begin
          case (op_code)
            OP_MTHI: begin
              hi_we = 1'b1;
              hi_d  = op_a;
            end
            OP_MTLO: begin
              lo_we = 1'b1;
              lo_d  = op_a;
            end
            OP_MULT, OP_MULTU: begin
              mul_start = 1'b1;
              sign_we   = 1'b1;
              cnt_load  = 1'b1;
              cnt_val   = CW'(MUL_LAT - 1);
              state_nx  = ST_MUL_WAIT;
            end
            OP_DIV, OP_DIVU: begin
              sign_we = 1'b1;
              if (op_b != '0) begin
                div_start = 1'b1;
                cnt_load  = 1'b1;
                state_nx  = ST_DIV_WAIT;
              end else begin
                // Divide by zero never reaches the divider.
                res_we   = 1'b1;
                res_hi_d = op_a;
                res_lo_d = '1;
                state_nx = ST_WB;
              end
            end
            default: ;
          endcase
        end
      end
      ST_MUL_WAIT: begin
        if (flush) begin
          state_nx = ST_IDLE;
        end else if (cnt == '0) begin
          res_we   = 1'b1;
          res_hi_d = mul_result[2*DATA_W-1:DATA_W];
          res_lo_d = mul_result[DATA_W-1:0];
          state_nx = ST_WB;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DIV_WAIT: begin
        if (flush) begin
          div_cancel = 1'b1;
          state_nx   = ST_IDLE;
        end else if (div_done) begin
          res_we   = 1'b1;
          res_hi_d = div_rem;
          res_lo_d = div_quot;
          state_nx = ST_WB;
        end else if (cnt == CW'(DIV_MAX_CYC - 1)) begin
          div_cancel = 1'b1;
          err_set    = 1'b1;
          state_nx   = ST_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_WB: begin
        state_nx = ST_IDLE;
        if (!flush) begin
          hi_we = 1'b1;
          lo_we = 1'b1;
          hi_d  = res_hi;
          lo_d  = res_lo;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      res_hi  <= '0;
      res_lo  <= '0;
      sign_q  <= 1'b0;
      div_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (hi_we)   hi_q    <= hi_d;
      if (lo_we)   lo_q    <= lo_d;
      if (res_we)  res_hi  <= res_hi_d;
      if (res_we)  res_lo  <= res_lo_d;
      if (sign_we) sign_q  <= is_signed_op(op_code);
      if (err_set) div_err <= 1'b1;
    end
  end

`ifdef HILO_FWD_EN
  assign hi        = (state == ST_WB) ? res_hi : hi_q;
  assign lo        = (state == ST_WB) ? res_lo : lo_q;
  assign hilo_busy = (state == ST_MUL_WAIT) || (state == ST_DIV_WAIT);
`else
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign hilo_busy = (state != ST_IDLE);
`endif

endmodule

// File: tb/tb_hilo_muldiv_sched.sv
// Scoreboard bench for hilo_muldiv_sched: reference model of HI/LO, external mul/div models.
module tb_hilo_muldiv_sched;

  localparam int MUL_LAT     = 2;
  localparam int DIV_MAX_CYC = 40;
  localparam logic [2:0] C_MULT = 3'd0, C_MULTU = 3'd1, C_DIV = 3'd2, C_DIVU = 3'd3,
                         C_MTHI = 3'd4, C_MTLO = 3'd5;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op_code = 3'd0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        flush = 1'b0;
  logic [63:0] mul_result;
  logic        div_done = 1'b0;
  logic [31:0] div_quot = 32'hDEAD_BEEF, div_rem = 32'hBAAD_F00D;
  logic        op_ready, mul_start, mul_signed, div_start, div_signed, div_cancel;
  logic [31:0] hi, lo;
  logic        hilo_busy, div_err;

  hilo_muldiv_sched #(.DATA_W(32), .MUL_LAT(MUL_LAT), .DIV_MAX_CYC(DIV_MAX_CYC)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_code(op_code), .op_a(op_a),
    .op_b(op_b), .op_ready(op_ready), .flush(flush), .mul_start(mul_start),
    .mul_signed(mul_signed), .mul_result(mul_result), .div_start(div_start),
    .div_signed(div_signed), .div_cancel(div_cancel), .div_done(div_done),
    .div_quot(div_quot), .div_rem(div_rem), .hi(hi), .lo(lo), .hilo_busy(hilo_busy),
    .div_err(div_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          due;
    logic [31:0] hi;
    logic [31:0] lo;
    int          tag;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  int   tag_n = 0;

  logic [31:0] hi_m = '0, lo_m = '0;

  function automatic logic [63:0] ref_mul(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // External multiplier: product valid only in the cycle MUL_LAT after mul_start.
  int          m_age = 0;
  logic [63:0] m_prod = '0;
  always @(posedge clk) begin
    if (mul_start) begin
      m_age  <= 1;
      m_prod <= ref_mul(op_code == C_MULT, op_a, op_b);
    end else if (m_age >= MUL_LAT) m_age <= 0;
    else if (m_age != 0) m_age <= m_age + 1;
  end
  assign mul_result = (m_age == MUL_LAT) ? m_prod : ~m_prod;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", nm, got, expv, cyc);
    end
  endtask

  task automatic push(input int due);
    exp_t e;
    e.due = due; e.hi = hi_m; e.lo = lo_m; e.tag = tag_n;
    tag_n++;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        mon_e = sbq.pop_front();
        checks++;
        if (mon_e.due != cyc || hi !== mon_e.hi || lo !== mon_e.lo || hilo_busy !== 1'b0) begin
          errors++;
          $display("FAIL sb_hilo tag=%0d cyc=%0d due=%0d: got hi=%h lo=%h busy=%b, expected hi=%h lo=%h busy=0",
                   mon_e.tag, cyc, mon_e.due, hi, lo, hilo_busy, mon_e.hi, mon_e.lo);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] oc, input logic [31:0] a, input logic [31:0] b, output int k);
    bit is_mul, is_div;
    is_mul = (oc == C_MULT) || (oc == C_MULTU);
    is_div = ((oc == C_DIV) || (oc == C_DIVU)) && (b != 0);
    op_valid = 1'b1; op_code = oc; op_a = a; op_b = b;
    #1;
    chk("op_ready", op_ready, 1'b1);
    chk("mul_start", mul_start, is_mul);
    chk("div_start", div_start, is_div);
    if (is_mul) chk("mul_signed", mul_signed, oc == C_MULT);
    if (is_div) chk("div_signed", div_signed, oc == C_DIV);
    tick();
    k = cyc;
    op_valid = 1'b0;
    #1;
    chk("start_pulse_len", {mul_start, div_start}, 2'b00);
  endtask

  task automatic run_op(input logic [2:0] oc, input logic [31:0] a, input logic [31:0] b, input int dly);
    int k, q_cyc;
    logic [63:0] p;
    logic [31:0] q, r;
    issue(oc, a, b, k);
    case (oc)
      C_MTHI: begin hi_m = a; push(k); end
      C_MTLO: begin lo_m = a; push(k); end
      C_MULT, C_MULTU: begin
        p = ref_mul(oc == C_MULT, a, b);
        hi_m = p[63:32]; lo_m = p[31:0];
        push(k + MUL_LAT + 1);
        repeat (MUL_LAT + 1) tick();
      end
      C_DIV, C_DIVU: begin
        if (b == 0) begin
          hi_m = a; lo_m = '1;
          push(k + 2);
          repeat (2) tick();
        end else begin
          ref_div(oc == C_DIV, a, b, q, r);
          repeat (dly) begin
            chk("op_ready_div_wait", op_ready, 1'b0);
            tick();
          end
          div_done = 1'b1; div_quot = q; div_rem = r;
          tick();
          div_done = 1'b0; div_quot = 32'hDEAD_BEEF; div_rem = 32'hBAAD_F00D;
          q_cyc = cyc;
          hi_m = r; lo_m = q;
          push(q_cyc + 1);
          tick();
        end
      end
      default: push(k);
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    logic [2:0]  oc;
    logic [31:0] a, b;

    repeat (3) tick();
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", hilo_busy, 1'b0);
    chk("rst_op_ready", op_ready, 1'b1);
    chk("rst_div_err", div_err, 1'b0);
    chk("rst_pulses", {mul_start, div_start, div_cancel}, 3'b000);
    resetn = 1'b1;
    tick();

    run_op(C_MULT, 32'hFFFF_FFFD, 32'd5, 0);
    chk("mult_neg3x5", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(C_DIVU, 32'd100, 32'd7, 10);
    chk("divu_100_7", {hi, lo}, {32'd2, 32'd14});
    run_op(C_DIV, 32'h1234, 32'd0, 0);
    chk("div_by_zero", {hi, lo}, {32'h1234, 32'hFFFF_FFFF});
    run_op(C_MTHI, 32'hA5A5, 32'd0, 0);
    run_op(C_MTLO, 32'h5A5A, 32'd0, 0);
    tick();
    chk("mthi_mtlo", {hi, lo}, {32'hA5A5, 32'h5A5A});

    // flush during MUL_WAIT
    issue(C_MULT, 32'd1234, 32'd99, k);
    flush = 1'b1; #1;
    chk("flush_mul_ready", op_ready, 1'b0);
    tick(); flush = 1'b0;
    push(cyc); push(cyc + MUL_LAT + 1);
    repeat (MUL_LAT + 2) tick();

    // flush together with div_done
    issue(C_DIV, 32'hFFFF_FF00, 32'd3, k);
    repeat (3) tick();
    flush = 1'b1; div_done = 1'b1; div_quot = 32'h1111_1111; div_rem = 32'h2222_2222; #1;
    chk("flush_div_cancel", div_cancel, 1'b1);
    tick(); flush = 1'b0; div_done = 1'b0;
    push(cyc); push(cyc + 2);
    repeat (3) tick();

    // flush in WB
    issue(C_DIVU, 32'h7777, 32'd0, k);
    flush = 1'b1; #1;
    chk("flush_wb_no_cancel", div_cancel, 1'b0);
    tick(); flush = 1'b0;
    push(cyc); push(cyc + 1);
    repeat (2) tick();

    // flush with op_valid in IDLE
    op_valid = 1'b1; op_code = C_MULT; op_a = 32'd5; op_b = 32'd6; flush = 1'b1; #1;
    chk("flush_idle_ready", op_ready, 1'b0);
    chk("flush_idle_no_start", mul_start, 1'b0);
    tick(); op_valid = 1'b0; flush = 1'b0;
    push(cyc);
    tick();

    for (int i = 0; i < 40; i++) begin
      oc = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ((oc == C_DIV || oc == C_DIVU) && $urandom_range(0, 3) == 0) b = '0;
      if (oc == C_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      run_op(oc, a, b, $urandom_range(1, 8));
    end

    // async reset while multiplier result is pending
    run_op(C_MTHI, 32'hCAFE_0001, 32'd0, 0);
    issue(C_MULTU, 32'd77, 32'd88, k);
    resetn = 1'b0; #1;
    hi_m = '0; lo_m = '0;
    chk("rst_mid_hilo", {hi, lo}, 64'h0);
    chk("rst_mid_busy", hilo_busy, 1'b0);
    chk("rst_mid_ready", op_ready, 1'b1);
    tick(); resetn = 1'b1;
    repeat (4) tick();
    chk("rst_mid_no_late_write", {hi, lo}, 64'h0);

    // divider watchdog
    run_op(C_MTLO, 32'h0BAD_C0DE, 32'd0, 0);
    chk("wd_err_before", div_err, 1'b0);
    issue(C_DIVU, 32'd500, 32'd9, k);
    for (int i = 0; i < DIV_MAX_CYC; i++) begin
      @(negedge clk);
      chk("wd_cancel", div_cancel, i == DIV_MAX_CYC - 1);
      chk("wd_ready_low", op_ready, 1'b0);
    end
    tick();
    chk("wd_err_set", div_err, 1'b1);
    chk("wd_ready_back", op_ready, 1'b1);
    push(cyc);
    tick();
    run_op(C_MULTU, 32'd3, 32'd4, 0);
    chk("wd_err_sticky", div_err, 1'b1);

    repeat (3) tick();
    chk("sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
